// File: rtl/dmem_resp_4c_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_resp_4c_pkg
//  Brief    : Shared types and constants for the multi-cycle data memory
//             responder (latency default, FSM states, index width helper).
//  Revision : 1.0  initial release
// ============================================================================
package dmem_resp_4c_pkg;

    localparam int unsigned DMEM_ADDR_W_DEFAULT  = 16;
    localparam int unsigned DMEM_LATENCY_DEFAULT = 4;
    localparam int unsigned DMEM_DATA_W          = 16;
    localparam int unsigned DMEM_CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } dmem_state_e;

    // Word index width: byte address minus the ignored LSB.
    function automatic int unsigned dmem_idx_w(input int unsigned addr_w);
        return addr_w - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_array
//  Brief    : 16-bit word storage; synchronous write, combinational read,
//             contents survive reset.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_array
    import dmem_resp_4c_pkg::*;
#(
    parameter int unsigned IDX_W = 15
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic [DMEM_DATA_W-1:0] wdata_i,
    output logic [DMEM_DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DMEM_DATA_W-1:0] mem_q [0:DEPTH-1];

    // Word write on the accepting edge; no reset so contents persist.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule
`default_nettype wire

// File: rtl/dmem_resp_4c.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_resp_4c
//  Brief    : Fixed-latency data memory for a CPU MEM stage. One request is
//             outstanding at a time; reads complete LATENCY cycles after the
//             request cycle with a one-cycle data_valid pulse.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_resp_4c
    import dmem_resp_4c_pkg::*;
#(
    parameter int unsigned ADDR_W  = DMEM_ADDR_W_DEFAULT,
    parameter int unsigned LATENCY = DMEM_LATENCY_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   wr,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DMEM_DATA_W-1:0] data_in,
    output logic [DMEM_DATA_W-1:0] data_out,
    output logic                   data_valid,
    output logic                   busy
);

    localparam int unsigned IDX_W = dmem_idx_w(ADDR_W);
    // Counter value of the last busy cycle; the following edge completes.
    localparam logic [DMEM_CNT_W-1:0] LAST_CNT = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_e            state_q, state_d;
    logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DMEM_DATA_W-1:0] hold_q;
    logic [DMEM_DATA_W-1:0] data_out_q;
    logic                   data_valid_q;

    logic [IDX_W-1:0]       word_idx;
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   accept;
    logic                   wr_accept;
    logic                   rd_accept;
    logic                   rd_done;
    logic                   unused_addr_lsb;

    // Byte address LSB is ignored: all accesses are whole words.
    assign word_idx        = addr[ADDR_W-1:1];
    assign unused_addr_lsb = addr[0];

    // Requests arriving while busy are dropped; reset gates the array write.
    assign accept    = enable & ~busy;
    assign wr_accept = accept & wr & rst_n;
    assign rd_accept = accept & ~wr;

    dmem_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_accept),
        .idx_i   (word_idx),
        .wdata_i (data_in),
        .rdata_o (rdata)
    );

    // State and cycle counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept from IDLE, count through the wait states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = wr ? WR_WAIT : RD_WAIT;
                    cnt_d   = DMEM_CNT_W'(1);
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DMEM_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from state: busy while waiting, read completes at last count.
    always_comb begin
        busy    = (state_q != IDLE);
        rd_done = (state_q == RD_WAIT) && (cnt_q == LAST_CNT);
    end

    // Read snapshot at acceptance and registered completion outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_done;
            if (rd_accept) begin
                hold_q <= rdata;
            end
            if (rd_done) begin
                data_out_q <= hold_q;
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp_4c.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_resp_4c
//  Brief    : Self-checking bench for dmem_resp_4c. Reads push the expected
//             word and completion cycle into a scoreboard; a negedge monitor
//             pops and compares when the completion cycle arrives.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_resp_4c;

    localparam int LAT = 4;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] model [int];

    dmem_resp_4c #(
        .ADDR_W  (16),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    // Free-running clock and cycle index.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: expected read completions and stray data_valid pulses.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            n_tests++;
            if (data_valid !== 1'b1 || data_out !== mon_e.data) begin
                n_fail++;
                $display("FAIL read_resp cyc=%0d: data_valid=%b data_out=%h, required data_valid=1 data_out=%h",
                         cyc, data_valid, data_out, mon_e.data);
            end
        end else if (data_valid === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_valid cyc=%0d: data_valid=1 data_out=%h, required data_valid=0",
                     cyc, data_out);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle; update the model / scoreboard if it should be taken.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, input bit acc);
        exp_t e;
        enable  = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        if (acc) begin
            if (w) begin
                model[int'(a[15:1])] = d;
            end else begin
                e.cyc  = cyc + LAT;
                e.data = model[int'(a[15:1])];
                sb.push_back(e);
            end
        end
        step();
        enable = 1'b0;
        wr     = 1'b0;
    endtask

    // Write and wait until the completion cycle.
    task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
        issue(1'b1, a, d, 1'b1);
        repeat (LAT - 1) step();
    endtask

    // Read and wait until the completion cycle (checked by the monitor).
    task automatic rd_word(input logic [15:0] a);
        issue(1'b0, a, 16'h0000, 1'b1);
        repeat (LAT - 1) step();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0040;
        data_in = 16'hDEAD;
        step();
        step();
        enable = 1'b0;
        wr     = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || data_valid !== 1'b0 || data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b data_valid=%b data_out=%h, required 0 0 0000",
                     busy, data_valid, data_out);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_write_read();
        issue(1'b1, 16'h0010, 16'hBEEF, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_busy cycle %0d: busy=%b, required 1", i, busy);
            end
            step();
        end
        n_tests++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done cycle 4: busy=%b data_valid=%b, required 0 0", busy, data_valid);
        end
        issue(1'b0, 16'h0010, 16'h0000, 1'b1);
        for (int i = 5; i <= 7; i++) begin
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rd_busy cycle %0d: busy=%b, required 1", i, busy);
            end
            step();
        end
        n_tests++;
        if (busy !== 1'b0 || data_valid !== 1'b1 || data_out !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rd_done cycle 8: busy=%b data_valid=%b data_out=%h, required 0 1 beef",
                     busy, data_valid, data_out);
        end
        step();
        n_tests++;
        if (data_valid !== 1'b0 || data_out !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rd_hold cycle 9: data_valid=%b data_out=%h, required 0 beef",
                     data_valid, data_out);
        end
    endtask

    task automatic test_dropped();
        wr_word(16'h0020, 16'h5555);
        issue(1'b0, 16'h0020, 16'h0000, 1'b1);
        step();
        issue(1'b1, 16'h0020, 16'h1234, 1'b0);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_busy cycle 3: busy=%b, required 1", busy);
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || data_valid !== 1'b1 || data_out !== 16'h5555) begin
            n_fail++;
            $display("FAIL drop_resp cycle 4: busy=%b data_valid=%b data_out=%h, required 0 1 5555",
                     busy, data_valid, data_out);
        end
        step();
        rd_word(16'h0020);
        step();
    endtask

    task automatic test_alias();
        wr_word(16'h0031, 16'hA5A5);
        rd_word(16'h0030);
        step();
    endtask

    task automatic test_reset_mid_op();
        issue(1'b0, 16'h0010, 16'h0000, 1'b1);
        step();
        rst_n = 1'b0;
        sb.delete();
        step();
        rst_n = 1'b1;
        n_tests++;
        if (busy !== 1'b0 || data_out !== 16'h0000 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrd_reset cycle 3: busy=%b data_out=%h data_valid=%b, required 0 0000 0",
                     busy, data_out, data_valid);
        end
        step();
        n_tests++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrd_novalid cycle 4: data_valid=%b, required 0", data_valid);
        end
        issue(1'b1, 16'h0060, 16'h6666, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midwr_reset: busy=%b, required 0", busy);
        end
        rd_word(16'h0060);
        step();
        wr_word(16'h0040, 16'h1111);
        rst_n   = 1'b0;
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0040;
        data_in = 16'hDEAD;
        step();
        rst_n  = 1'b1;
        enable = 1'b0;
        wr     = 1'b0;
        step();
        rd_word(16'h0040);
        step();
    endtask

    task automatic test_back_to_back();
        wr_word(16'h0000, 16'h0A0A);
        wr_word(16'h0002, 16'h0B0B);
        issue(1'b0, 16'h0000, 16'h0000, 1'b1);
        repeat (3) step();
        n_tests++;
        if (data_valid !== 1'b1 || data_out !== 16'h0A0A) begin
            n_fail++;
            $display("FAIL b2b_first cycle 4: data_valid=%b data_out=%h, required 1 0a0a",
                     data_valid, data_out);
        end
        issue(1'b0, 16'h0002, 16'h0000, 1'b1);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept cycle 5: busy=%b, required 1", busy);
        end
        repeat (3) step();
        step();
    endtask

    task automatic test_wrap();
        wr_word(16'hFFFE, 16'h7777);
        rd_word(16'hFFFF);
        step();
        rd_word(16'h0000);
        step();
    endtask

    task automatic test_drain();
        repeat (LAT + 2) step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d reads never completed, required 0", sb.size());
        end
    endtask

    initial begin
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0000;
        data_in = 16'h0000;
        rst_n   = 1'b0;
        test_reset();
        test_write_read();
        test_dropped();
        test_alias();
        test_reset_mid_op();
        test_back_to_back();
        test_wrap();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
